// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main control FSM: opcodes, states and
// the control-word fields driven toward the datapath.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } srcb_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

    typedef struct packed {
        logic   ir_write;
        logic   mem_read;
        logic   mem_write;
        logic   iord;
        logic   pc_write;
        logic   pc_write_cond;
        pcsrc_t pc_source;
        aluop_t alu_op;
        logic   alu_src_a;
        srcb_t  alu_src_b;
        logic   reg_write;
        logic   reg_dst;
        logic   mem_to_reg;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Moore decode of the current state into the raw control word; handshake
// gating and reset masking are applied by the parent.
module mc_out_decode
    import mc_pkg::*;
(
    input  state_t cur_state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (cur_state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute, waits on the
// memory handshake and counts retired instructions.
module mc_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [5:0]       opCode,
    input  logic             zero,
    input  logic             memReady,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             illegalOp,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instCount
);

    state_t cur_state;
    ctrl_t  ctrl;
    logic   fetch_done;
    logic   unused_zero;

    // The branch condition is resolved in the datapath through PCWriteCond.
    assign unused_zero = zero;

    mc_out_decode u_out_decode (
        .cur_state (cur_state),
        .ctrl      (ctrl)
    );

    always_ff @(posedge clk) begin
        if (!rstN) begin
            cur_state <= S_FETCH;
            instCount <= '0;
        end else begin
            case (cur_state)
                S_FETCH:  if (memReady) cur_state <= S_DECODE;
                S_DECODE: begin
                    case (opCode)
                        OP_LW, OP_SW: cur_state <= S_MEMADR;
                        OP_RTYPE:     cur_state <= S_REXEC;
                        OP_BEQ:       cur_state <= S_BEQ;
                        OP_J:         cur_state <= S_JUMP;
                        OP_ADDI:      cur_state <= S_ADDIEX;
                        default:      cur_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: cur_state <= (opCode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (memReady) cur_state <= S_MEMWB;
                S_MEMWR: begin
                    if (memReady) begin
                        cur_state <= S_FETCH;
                        instCount <= instCount + CNT_W'(1);
                    end
                end
                S_REXEC:  cur_state <= S_RWB;
                S_ADDIEX: cur_state <= S_ADDIWB;
                S_MEMWB, S_RWB, S_BEQ, S_JUMP, S_ADDIWB: begin
                    cur_state <= S_FETCH;
                    instCount <= instCount + CNT_W'(1);
                end
                default:  cur_state <= S_FETCH;
            endcase
        end
    end

    // FETCH writes IR and PC only in the cycle memory returns the word.
    assign fetch_done  = (cur_state != S_FETCH) || memReady;

    assign IRWrite     = rstN & ctrl.ir_write & memReady;
    assign MemRead     = rstN & ctrl.mem_read;
    assign MemWrite    = rstN & ctrl.mem_write;
    assign PCWrite     = rstN & ctrl.pc_write & fetch_done;
    assign PCWriteCond = rstN & ctrl.pc_write_cond;
    assign RegWrite    = rstN & ctrl.reg_write;
    assign IorD        = ctrl.iord;
    assign PCSource    = ctrl.pc_source;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign RegDst      = ctrl.reg_dst;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign illegalOp   = rstN && (cur_state == S_DECODE) && !op_legal(opCode);
    assign state       = cur_state;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: instruction-level reference model expands each opcode
// into its expected cycle sequence, with random memory stalls and opcodes.
module tb_mc_control;
    import mc_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstN;
    logic [5:0]       opCode;
    logic             zero;
    logic             memReady;
    logic             IRWrite, MemRead, MemWrite, IorD, PCWrite, PCWriteCond;
    logic [1:0]       PCSource, ALUOp, ALUSrcB;
    logic             ALUSrcA, RegWrite, RegDst, MemtoReg, illegalOp;
    logic [3:0]       dut_state;
    logic [CNT_W-1:0] instCount;

    int n_cmp = 0;
    int n_bad = 0;
    int model_cnt = 0;

    mc_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rstN(rstN), .opCode(opCode), .zero(zero), .memReady(memReady),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .illegalOp(illegalOp),
        .state(dut_state), .instCount(instCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ctl(bit irw, bit mrd, bit mwr, bit iord, bit pcw,
                                        bit pcwc, logic [1:0] pcs, logic [1:0] aop,
                                        bit asa, logic [1:0] asb, bit rw, bit rd, bit m2r);
        return {irw, mrd, mwr, iord, pcw, pcwc, pcs, aop, asa, asb, rw, rd, m2r};
    endfunction

    // Expected control word per phase, straight from the state table.
    function automatic logic [15:0] exp_ctrl(state_t ph, bit mr);
        case (ph)
            S_FETCH:  return ctl(mr, 1, 0, 0, mr, 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0);
            S_DECODE: return ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 0, 0);
            S_MEMADR: return ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0);
            S_MEMRD:  return ctl(0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
            S_MEMWB:  return ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 1);
            S_MEMWR:  return ctl(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
            S_REXEC:  return ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 2'b00, 0, 0, 0);
            S_RWB:    return ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 1, 0);
            S_BEQ:    return ctl(0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 1, 2'b00, 0, 0, 0);
            S_JUMP:   return ctl(0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0);
            S_ADDIEX: return ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0);
            S_ADDIWB: return ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0);
            default:  return 16'h0;
        endcase
    endfunction

    function automatic bit legal(logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 time unit later.
    task automatic step(input state_t ph, input bit mr, input bit ill, input logic [5:0] op);
        logic [15:0] got;
        @(negedge clk);
        opCode   = op;
        memReady = mr;
        zero     = 1'($urandom);
        #1;
        got = {IRWrite, MemRead, MemWrite, IorD, PCWrite, PCWriteCond, PCSource,
               ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, MemtoReg};
        chk("state", 32'(dut_state), 32'(ph));
        chk("ctrl", 32'(got), 32'(exp_ctrl(ph, mr)));
        chk("illegalOp", 32'(illegalOp), 32'(ill));
        chk("instCount", 32'(instCount), 32'(model_cnt));
    endtask

    task automatic run_inst(input logic [5:0] op, input int fs, input int ms);
        for (int i = 0; i < fs; i++) step(S_FETCH, 1'b0, 1'b0, op);
        step(S_FETCH, 1'b1, 1'b0, op);
        step(S_DECODE, 1'($urandom), !legal(op), op);
        case (op)
            6'b100011: begin
                step(S_MEMADR, 1'($urandom), 1'b0, op);
                for (int i = 0; i < ms; i++) step(S_MEMRD, 1'b0, 1'b0, op);
                step(S_MEMRD, 1'b1, 1'b0, op);
                step(S_MEMWB, 1'($urandom), 1'b0, op);
            end
            6'b101011: begin
                step(S_MEMADR, 1'($urandom), 1'b0, op);
                for (int i = 0; i < ms; i++) step(S_MEMWR, 1'b0, 1'b0, op);
                step(S_MEMWR, 1'b1, 1'b0, op);
            end
            6'b000000: begin
                step(S_REXEC, 1'($urandom), 1'b0, op);
                step(S_RWB, 1'($urandom), 1'b0, op);
            end
            6'b000100: step(S_BEQ, 1'($urandom), 1'b0, op);
            6'b000010: step(S_JUMP, 1'($urandom), 1'b0, op);
            6'b001000: begin
                step(S_ADDIEX, 1'($urandom), 1'b0, op);
                step(S_ADDIWB, 1'($urandom), 1'b0, op);
            end
            default: ;
        endcase
        if (legal(op)) model_cnt = (model_cnt + 1) % (1 << CNT_W);
    endtask

    task automatic do_reset(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rstN     = 1'b0;
            memReady = 1'($urandom);
            #1;
            chk("rst_enables", 32'({IRWrite, MemRead, MemWrite, PCWrite, PCWriteCond, RegWrite}), 32'h0);
        end
        @(negedge clk);
        rstN      = 1'b1;
        memReady  = 1'b0;
        model_cnt = 0;
        #1;
        chk("rst_state", 32'(dut_state), 32'(S_FETCH));
        chk("rst_count", 32'(instCount), 32'h0);
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        int         fs;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
        rstN = 1'b0; opCode = 6'b0; zero = 1'b0; memReady = 1'b0;
        do_reset(2);

        run_inst(6'b100011, 0, 0);
        run_inst(6'b000010, 3, 0);
        run_inst(6'b101011, 0, 2);
        run_inst(6'b000100, 0, 0);
        run_inst(6'b000010, 0, 0);
        run_inst(6'b000000, 1, 0);
        run_inst(6'b001000, 0, 0);
        run_inst(6'b111111, 0, 0);

        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 6'b111111) op = 6'($urandom);
            fs = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_inst(op, fs, $urandom_range(0, 3));
        end

        // Abandon a load mid-flight.
        step(S_FETCH, 1'b1, 1'b0, 6'b100011);
        step(S_DECODE, 1'b1, 1'b0, 6'b100011);
        step(S_MEMADR, 1'b1, 1'b0, 6'b100011);
        do_reset(2);

        for (int n = 0; n < 16; n++) run_inst(6'b000010, 0, 0);
        step(S_FETCH, 1'b0, 1'b0, 6'b000000);
        chk("wrap", 32'(instCount), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle main control FSM: the other end of the instruction-register interface.
- Drives IRWrite and the memory-read strobe that fill the instruction register, then consumes the latched opCode to sequence execution.
- Sits beside the datapath and drives every mux select and write enable.
- Memory is variable-latency; each memory-phase state waits on a memReady handshake.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rstN  in  1  synchronous active-low reset
- opCode  in  6  inst[31:26] from the instruction register
- zero  in  1  ALU zero flag
- memReady  in  1  memory completes the current access this cycle
- IRWrite  out  1  load instruction register
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IorD  out  1  0 = PC address, 1 = ALUOut address
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write if zero
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- ALUSrcA  out  1  0 PC, 1 register A
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
- RegWrite  out  1  register file write
- RegDst  out  1  0 Rt, 1 Rd
- MemtoReg  out  1  0 ALUOut, 1 MDR
- illegalOp  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug
- instCount  out  CNT_W  retired instructions

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BEQ, JUMP, ADDIEX, ADDIWB.
- Reset:
  - rstN low at a clk edge -> state = FETCH and instCount = 0.
  - While rstN is low, all write enables and request strobes (IRWrite, MemRead, MemWrite, PCWrite, PCWriteCond, RegWrite) are forced to 0 combinationally.
  - Reset mid-instruction abandons it with no further writes.
- Outputs are Moore-decoded from state. The exceptions are IRWrite, PCWrite in FETCH, and the MEMRD/MEMWR exits, which are gated by memReady.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=memReady.
  - memReady=1 -> DECODE, else stay in FETCH with no writes.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state: LW/SW -> MEMADR; RTYPE -> REXEC; BEQ -> BEQ; J -> JUMP; ADDI -> ADDIEX.
  - Any other opcode -> FETCH with illegalOp=1 for this cycle only; the instruction is not counted.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Waits for memReady, then -> MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for memReady, then -> FETCH.
  - MemWrite stays high through the whole wait, and the address is held stable.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- instCount:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BEQ, JUMP or ADDIWB.
  - Wraps from all-ones to 0.
- Latency with memReady tied high:
  - LW 5 cycles.
  - SW, R-type and ADDI 4 cycles.
  - BEQ and J 3 cycles.
  - Each memReady-low cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Unspecified outputs are 0 in every state.

Decomposition:
- Package mc_pkg holds:
  - opcode constants;
  - the state enumeration (4-bit);
  - ALUOp, ALUSrcB and PCSource encodings.
- One sub-module, mc_out_decode: combinational state -> control-word decode, with memReady gating applied in the parent.
- Next-state logic and instCount stay in mc_control.

Test Plan:
- Reset: rstN=0 for 2 cycles with an arbitrary state -> state=FETCH, instCount=0, all enables 0 while rstN=0.
- LW, memReady=1: opCode=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB.
  - IRWrite=1 in cycle 0; RegWrite=1 with MemtoReg=1 in cycle 4.
  - instCount goes 0->1.
- FETCH stall: memReady=0 for 3 cycles, then 1 -> FETCH held for 4 cycles.
  - IRWrite=PCWrite=0 for 3 cycles, then 1 for exactly 1 cycle.
- SW with a MEMWR stall: opCode=101011, memReady=0 for 2 cycles in MEMWR.
  - MemWrite=1 and IorD=1 for 3 consecutive cycles, then FETCH.
- BEQ and J: opCode=000100 -> PCWriteCond=1, PCSource=01 in cycle 2; opCode=000010 -> PCWrite=1, PCSource=10 in cycle 2.
  - Both return to FETCH at cycle 3.
- Illegal opcode: opCode=111111 -> DECODE then FETCH, illegalOp=1 for exactly 1 cycle, instCount unchanged.
- Counter wrap: CNT_W=4, run 16 J instructions -> instCount returns to 0.
